// File: rtl/seven_seg_capture.sv
// Recovers digit codes from a multiplexed 7-segment bus. A slot is captured once its
// {seg, digit_sel} sample has been steady; a full set of slots is offered as a frame.
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] frame_digits,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SMP_W = 7 + NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Returns {err, code}; blank maps to F without error, unknown patterns to E with error.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            7'b0000000: r = 5'h0F;
            default:    r = 5'h1E;
        endcase
        return r;
    endfunction

    logic [SMP_W-1:0]        r_prev;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [4*NUM_DIGITS-1:0] r_slot_codes;
    logic [NUM_DIGITS-1:0]   r_slot_errs;
    logic [4*NUM_DIGITS-1:0] r_frame_digits;
    logic [NUM_DIGITS-1:0]   r_frame_err;
    logic                    r_frame_valid;
    logic                    r_overrun;

    logic [SMP_W-1:0]        w_sample;
    logic                    w_onehot;
    logic                    w_same;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_capture;
    logic                    w_complete;
    logic                    w_accept;
    logic [4:0]              w_dec;
    logic [4*NUM_DIGITS-1:0] w_codes_next;
    logic [NUM_DIGITS-1:0]   w_errs_next;

    assign w_sample = {seg, digit_sel};
    assign w_onehot = $onehot(digit_sel);
    // r_cnt != 0 guarantees r_prev was itself an eligible sample.
    assign w_same   = w_onehot && (w_sample == r_prev) && (r_cnt != '0);

    always_comb begin
        w_cnt_next = '0;
        if (w_onehot) begin
            if (!w_same)
                w_cnt_next = CNT_ONE;
            else if (r_cnt == CNT_FULL)
                w_cnt_next = r_cnt;
            else
                w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    // Fires only on the transition into the full count, so one capture per stable run.
    assign w_capture  = w_onehot && (w_cnt_next == CNT_FULL) && (r_cnt != CNT_FULL);
    assign w_complete = w_capture && ((r_mask | digit_sel) == {NUM_DIGITS{1'b1}});
    assign w_accept   = r_frame_valid && frame_ready;
    assign w_dec      = decode_seg(seg);

    always_comb begin
        w_codes_next = r_slot_codes;
        w_errs_next  = r_slot_errs;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel[i]) begin
                w_codes_next[4*i +: 4] = w_dec[3:0];
                w_errs_next[i]         = w_dec[4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_slot_codes <= w_codes_next;
            r_slot_errs  <= w_errs_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev         <= '0;
            r_cnt          <= '0;
            r_mask         <= '0;
            r_frame_digits <= '0;
            r_frame_err    <= '0;
            r_frame_valid  <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_prev    <= w_sample;
            r_cnt     <= w_cnt_next;
            r_overrun <= 1'b0;
            if (w_accept)
                r_frame_valid <= 1'b0;
            if (w_capture)
                r_mask <= w_complete ? '0 : (r_mask | digit_sel);
            // A held, unaccepted frame is kept; the newer one is dropped and flagged.
            if (w_complete) begin
                if (!r_frame_valid || w_accept) begin
                    r_frame_digits <= w_codes_next;
                    r_frame_err    <= w_errs_next;
                    r_frame_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign frame_digits = r_frame_digits;
    assign frame_err    = r_frame_err;
    assign frame_valid  = r_frame_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: a history-based reference model checked every cycle on a
// 4-digit instance, plus directed literal checks on 4-digit and 1-digit instances.
module tb_seven_seg_capture;

    localparam int N  = 4;
    localparam int SC = 4;

    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
    localparam logic [6:0] TBL [10] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [6:0]    seg = '0;
    logic [N-1:0]  sel = '0;
    logic          rdy = 1'b0;
    logic [4*N-1:0] digits;
    logic [N-1:0]  err;
    logic          valid, ovr;

    logic [6:0]    seg1 = '0;
    logic [0:0]    sel1 = '0;
    logic          rdy1 = 1'b0;
    logic [3:0]    digits1;
    logic [0:0]    err1;
    logic          valid1, ovr1;

    seven_seg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut4 (
        .clk(clk), .rst(rst), .seg(seg), .digit_sel(sel),
        .frame_digits(digits), .frame_err(err), .frame_valid(valid),
        .frame_ready(rdy), .overrun(ovr)
    );

    seven_seg_capture #(.NUM_DIGITS(1), .STABLE_CYCLES(SC)) dut1 (
        .clk(clk), .rst(rst), .seg(seg1), .digit_sel(sel1),
        .frame_digits(digits1), .frame_err(err1), .frame_valid(valid1),
        .frame_ready(rdy1), .overrun(ovr1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (s == TBL[i]) return {1'b0, 4'(i)};
        if (s == 7'b0) return 5'h0F;
        return 5'h1E;
    endfunction

    // Reference model: run length is recounted from the recent sample history each edge.
    logic [11:0]    hist [$];
    logic [3:0]     m_code [N];
    logic           m_err  [N];
    logic           m_have [N];
    logic [4*N-1:0] e_digits = '0;
    logic [N-1:0]   e_err = '0;
    logic           e_valid = 1'b0, e_ovr = 1'b0;
    int             m_run, m_slot;
    logic           m_acc, m_all;
    logic [4:0]     m_dec;

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            for (int i = 0; i < N; i++) m_have[i] = 1'b0;
            e_digits = '0; e_err = '0; e_valid = 1'b0; e_ovr = 1'b0;
        end else begin
            m_acc = e_valid && rdy;
            e_ovr = 1'b0;
            if (m_acc) e_valid = 1'b0;
            hist.push_back({($countones(sel) == 1), seg, sel});
            if (hist.size() > 8) void'(hist.pop_front());
            m_run = 0;
            for (int k = hist.size() - 1; k >= 0; k--) begin
                if (hist[k] == {1'b1, seg, sel}) m_run++;
                else break;
            end
            if (m_run == SC) begin
                m_slot = 0;
                for (int i = 0; i < N; i++) if (sel[i]) m_slot = i;
                m_dec = m_decode(seg);
                m_code[m_slot] = m_dec[3:0];
                m_err[m_slot]  = m_dec[4];
                m_have[m_slot] = 1'b1;
                m_all = 1'b1;
                for (int i = 0; i < N; i++) m_all = m_all && m_have[i];
                if (m_all) begin
                    for (int i = 0; i < N; i++) m_have[i] = 1'b0;
                    if (!e_valid) begin
                        for (int i = 0; i < N; i++) begin
                            e_digits[4*i +: 4] = m_code[i];
                            e_err[i] = m_err[i];
                        end
                        e_valid = 1'b1;
                    end else begin
                        e_ovr = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_valid", 32'(valid), 32'(e_valid));
        chk("model_overrun", 32'(ovr), 32'(e_ovr));
        if (e_valid) begin
            chk("model_digits", 32'(digits), 32'(e_digits));
            chk("model_err", 32'(err), 32'(e_err));
        end
    end

    task automatic cyc(input logic [6:0] s, input logic [N-1:0] d, input logic r);
        seg = s; sel = d; rdy = r;
        @(posedge clk); #1;
    endtask

    task automatic show(input int slot, input logic [6:0] s, input logic r);
        repeat (SC) cyc(s, N'(1 << slot), r);
    endtask

    task automatic cyc1;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_overrun", 32'(ovr), 32'd0);
        chk("rst_valid1", 32'(valid1), 32'd0);
        rst = 1'b0;

        // Single-digit instance: capture on the 4th steady edge, exactly one frame.
        seg1 = P0; sel1 = 1'b1; rdy1 = 1'b0;
        for (int e = 1; e <= SC; e++) begin
            cyc1();
            if (e < SC) chk("t1_early_valid", 32'(valid1), 32'd0);
        end
        chk("t1_valid", 32'(valid1), 32'd1);
        chk("t1_digit", 32'(digits1), 32'h0);
        chk("t1_err", 32'(err1), 32'd0);
        repeat (4) begin
            cyc1();
            chk("t1_hold_valid", 32'(valid1), 32'd1);
            chk("t1_no_overrun", 32'(ovr1), 32'd0);
        end
        rdy1 = 1'b1;
        cyc1();
        chk("t1_xfer_valid", 32'(valid1), 32'd0);
        repeat (4) begin
            cyc1();
            chk("t1_one_frame", 32'(valid1), 32'd0);
        end

        // Basic frame 1,2,3,4 with consumer ready.
        show(0, P1, 1'b1); show(1, P2, 1'b1); show(2, P3, 1'b1); show(3, P4, 1'b1);
        chk("t2_valid", 32'(valid), 32'd1);
        chk("t2_digits", 32'(digits), 32'h4321);
        chk("t2_err", 32'(err), 32'd0);
        cyc(7'b0, '0, 1'b1);
        chk("t2_valid_drop", 32'(valid), 32'd0);

        // Blank and invalid patterns, held (not ready).
        show(0, P5, 1'b0); show(1, 7'b0000000, 1'b0); show(2, 7'b1000000, 1'b0); show(3, P9, 1'b0);
        chk("t3_valid", 32'(valid), 32'd1);
        chk("t3_digits", 32'(digits), 32'h9EF5);
        chk("t3_err", 32'(err), 32'b0100);

        // Second frame while first is held -> overrun, first frame kept.
        show(0, P7, 1'b0); show(1, P8, 1'b0); show(2, P6, 1'b0); show(3, P0, 1'b0);
        chk("t5_overrun", 32'(ovr), 32'd1);
        chk("t5_digits_kept", 32'(digits), 32'h9EF5);
        cyc(7'b0, '0, 1'b0);
        chk("t5_overrun_pulse", 32'(ovr), 32'd0);
        chk("t5_still_valid", 32'(valid), 32'd1);
        cyc(7'b0, '0, 1'b1);
        chk("t5_xfer_valid", 32'(valid), 32'd0);

        // Interrupted run and multi-hot select must not capture.
        cyc(P1, 4'b0001, 1'b1); cyc(P1, 4'b0001, 1'b1);
        cyc(P2, 4'b0001, 1'b1); cyc(P2, 4'b0001, 1'b1);
        repeat (6) cyc(P3, 4'b0011, 1'b1);
        cyc(7'b0, '0, 1'b1);
        show(1, P1, 1'b1); show(2, P2, 1'b1); show(3, P3, 1'b1);
        chk("t4_no_frame", 32'(valid), 32'd0);
        show(0, P7, 1'b1);
        chk("t4_valid", 32'(valid), 32'd1);
        chk("t4_digits", 32'(digits), 32'h3217);
        cyc(7'b0, '0, 1'b1);

        // Reset mid-frame while a frame is held.
        show(0, P1, 1'b0); show(1, P2, 1'b0); show(2, P3, 1'b0); show(3, P4, 1'b0);
        chk("t6_pre_valid", 32'(valid), 32'd1);
        show(0, P5, 1'b0); show(1, P6, 1'b0);
        rst = 1'b1;
        cyc(P7, 4'b0100, 1'b0);
        chk("t6_rst_valid", 32'(valid), 32'd0);
        chk("t6_rst_digits", 32'(digits), 32'd0);
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_overrun", 32'(ovr), 32'd0);
        rst = 1'b0;
        show(2, P7, 1'b0); show(3, P8, 1'b0);
        chk("t6_mask_cleared", 32'(valid), 32'd0);
        show(2, P9, 1'b0); show(0, P1, 1'b0); show(1, P2, 1'b0);
        chk("t6_valid", 32'(valid), 32'd1);
        chk("t6_digits_overwrite", 32'(digits), 32'h8921);
        cyc(7'b0, '0, 1'b1);
        cyc(7'b0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
